// File: rtl/ifetch.sv
// Instruction fetch unit: streams 32-bit words from a 4-byte-wide ROM into a
// small instruction buffer and hands them to the consumer with valid/ready.
// Optional build macro IFETCH_ALIGN_CHECK_EN: a misaligned redirect raises a
// sticky fault and halts fetching until reset. When the macro is undefined,
// the low bits of redirect_pc are dropped and fault stays 0.
module ifetch #(
    parameter logic [15:0] RESET_PC   = 16'h8000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] mem_a,
    output logic        mem_re,
    input  logic [7:0]  mem_q0,
    input  logic [7:0]  mem_q1,
    input  logic [7:0]  mem_q2,
    input  logic [7:0]  mem_q3,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [15:0] instr_pc,
    output logic        fault
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = CW + 1;

    typedef struct packed {
        logic [15:0] pc;
        logic [31:0] word;
    } entry_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t         state, state_nxt;
    entry_t         fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]  head, tail;
    logic [CW-1:0]  count;
    logic           inflight;
    logic [15:0]    fetch_pc;
    logic [15:0]    last_a;

    logic           issue_c;
    logic           push_c;
    logic           pop_c;
    logic           misalign_c;
    logic [15:0]    redirect_aligned_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Next-state and request decision; a request needs a free slot counting in-flight data
    always_comb begin
        state_nxt          = state;
        issue_c            = 1'b0;
        misalign_c         = 1'b0;
        redirect_aligned_c = redirect_pc & 16'hFFFC;
`ifdef IFETCH_ALIGN_CHECK_EN
        misalign_c         = redirect && (redirect_pc[1:0] != 2'b00);
`endif
        case (state)
            ST_RUN: begin
                if (misalign_c) begin
                    state_nxt = ST_HALT;
                end else begin
                    issue_c = !rst && !redirect &&
                              ((OW'(count) + OW'(inflight)) < OW'(FIFO_DEPTH));
                end
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_RUN;
        endcase
        push_c = inflight && !redirect;
        pop_c  = (count != '0) && instr_ready;
    end

    // ROM port and consumer-side views; mem_a holds the last issued address when idle
    always_comb begin
        mem_re      = issue_c;
        mem_a       = issue_c ? fetch_pc : last_a;
        instr_valid = (count != '0);
        instr       = instr_valid ? fifo_mem[head].word : 32'h0;
        instr_pc    = instr_valid ? fifo_mem[head].pc   : 16'h0;
        fault       = (state == ST_HALT);
    end

    // Control state: FSM, fetch pointer, in-flight flag and buffer bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_RUN;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            inflight <= 1'b0;
            fetch_pc <= RESET_PC;
            last_a   <= RESET_PC;
        end else begin
            state    <= state_nxt;
            inflight <= issue_c;
            if (issue_c) begin
                last_a <= fetch_pc;
            end
            if (redirect) begin
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                fetch_pc <= redirect_aligned_c;
            end else begin
                if (issue_c) begin
                    fetch_pc <= fetch_pc + 16'd4;
                end
                if (push_c) begin
                    tail <= ptr_inc(tail);
                end
                if (pop_c) begin
                    head <= ptr_inc(head);
                end
                count <= count + CW'(push_c) - CW'(pop_c);
            end
        end
    end

    // Buffer storage; the captured word is tagged with the address that requested it
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_mem[tail] <= '{pc: last_a, word: {mem_q3, mem_q2, mem_q1, mem_q0}};
        end
    end

endmodule
